// File: rtl/bram_vec_loader_pkg.sv
// Shared definitions for the ping-pong vector loader: default geometry,
// FSM encoding and a small index-width helper.
package bram_vec_loader_pkg;

   localparam int WIDTH_DEF    = 8;
   localparam int LENGTH_DEF   = 32;
   localparam int CHANNELS_DEF = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   // Index width that stays at least one bit for degenerate sizes.
   function automatic int idx_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bram_vec_loader_if.sv
// Control, input-stream and output-vector signals of the loader, bundled.
// The loader sits on the slave side; the run controller/producer/consumer on the master side.
interface bram_vec_loader_if
   import bram_vec_loader_pkg::*;
#(
   parameter int WIDTH    = WIDTH_DEF,
   parameter int LENGTH   = LENGTH_DEF,
   parameter int CHANNELS = CHANNELS_DEF
);
   localparam int CW = $clog2(CHANNELS + 1);

   logic                      start;
   logic [CW-1:0]             ch_count;
   logic                      abort;
   logic                      in_valid;
   logic [WIDTH-1:0]          in_data;
   logic                      in_ready;
   logic                      out_valid;
   logic                      out_ready;
   logic [WIDTH*LENGTH-1:0]   out_data;
   logic [CW-1:0]             out_ch;
   logic                      out_last;
   logic                      busy;
   logic                      done;

   modport master (
      output start, ch_count, abort, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_ch, out_last, busy, done
   );

   modport slave (
      input  start, ch_count, abort, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_ch, out_last, busy, done
   );

endinterface

// File: rtl/bram_vec_loader_bank.sv
// One ping-pong bank: LENGTH element registers plus full flag, channel tag
// and last-of-run marker captured when the final element lands.
module bram_vec_loader_bank
   import bram_vec_loader_pkg::*;
#(
   parameter int WIDTH  = WIDTH_DEF,
   parameter int LENGTH = LENGTH_DEF,
   parameter int CW     = 3,
   localparam int IW    = idx_bits(LENGTH)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wr_en,
   input  logic [IW-1:0]           wr_idx,
   input  logic [WIDTH-1:0]        wr_data,
   input  logic                    set_full,
   input  logic [CW-1:0]           tag_in,
   input  logic                    last_in,
   input  logic                    clr,
   input  logic                    flush,
   output logic [WIDTH*LENGTH-1:0] data,
   output logic                    full,
   output logic [CW-1:0]           tag,
   output logic                    last
);

   logic [WIDTH-1:0] mem [LENGTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < LENGTH; k++) mem[k] <= '0;
         full <= 1'b0;
         tag  <= '0;
         last <= 1'b0;
      end else begin
         if (wr_en) mem[wr_idx] <= wr_data;
         if (flush) begin
            full <= 1'b0;
            tag  <= '0;
            last <= 1'b0;
         end else if (set_full) begin
            full <= 1'b1;
            tag  <= tag_in;
            last <= last_in;
         end else if (clr) begin
            full <= 1'b0;
         end
      end
   end

   always_comb begin
      data = '0;
      for (int k = 0; k < LENGTH; k++) data[k*WIDTH +: WIDTH] = mem[k];
   end

endmodule

// File: rtl/bram_vec_loader.sv
// Packs a WIDTH-bit element stream into LENGTH-element channel vectors through
// two ping-pong banks, presenting vectors oldest-first on a valid/ready port.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no run; banks empty, waiting for start with ch_count != 0
//   FILL  | accepting elements until the last channel's last element
//   DRAIN | all data in; waiting for the last vector to be taken
module bram_vec_loader
   import bram_vec_loader_pkg::*;
#(
   parameter int WIDTH    = WIDTH_DEF,
   parameter int LENGTH   = LENGTH_DEF,
   parameter int CHANNELS = CHANNELS_DEF
) (
   input logic              clk,
   input logic              global_rst,
   bram_vec_loader_if.slave bus
);

   localparam int CW = $clog2(CHANNELS + 1);
   localparam int IW = idx_bits(LENGTH);
   localparam int VW = WIDTH * LENGTH;

   state_t        state_q, state_d;
   logic [IW-1:0] elem_q;
   logic [CW-1:0] ch_fill_q, ch_total_q, ch_eff;
   logic          wr_ptr_q, rd_ptr_q;
   logic          in_ready, accept, hs, elem_last, ch_last, run_done, start_ok;
   logic          busy, done;

   logic [VW-1:0] bank_data [2];
   logic          bank_full [2];
   logic [CW-1:0] bank_tag  [2];
   logic          bank_last [2];

   logic          sel_full, sel_last;
   logic [CW-1:0] sel_tag;
   logic [VW-1:0] sel_data;

   assign ch_eff   = (bus.ch_count > CW'(CHANNELS)) ? CW'(CHANNELS) : bus.ch_count;
   assign start_ok = bus.start && (ch_eff != '0);

   assign sel_full = bank_full[rd_ptr_q];
   assign sel_last = bank_last[rd_ptr_q];
   assign sel_tag  = bank_tag[rd_ptr_q];
   assign sel_data = bank_data[rd_ptr_q];

   // abort wins over any same-cycle write or handshake
   assign in_ready  = (state_q == ST_FILL) & ~bank_full[wr_ptr_q];
   assign accept    = bus.in_valid & in_ready & ~bus.abort;
   assign hs        = sel_full & bus.out_ready & ~bus.abort;
   assign elem_last = (elem_q == IW'(LENGTH - 1));
   assign ch_last   = (ch_fill_q == ch_total_q - CW'(1));
   assign run_done  = accept & elem_last & ch_last;

   always_ff @(posedge clk or posedge global_rst) begin
      if (global_rst) state_q <= ST_IDLE;
      else            state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      done    = 1'b0;
      busy    = (state_q != ST_IDLE);
      case (state_q)
         ST_IDLE:  if (start_ok) state_d = ST_FILL;
         ST_FILL:  if (run_done) state_d = ST_DRAIN;
         ST_DRAIN: begin
            if (hs && sel_last) begin
               state_d = ST_IDLE;
               done    = 1'b1;
            end
         end
         default:  state_d = ST_IDLE;
      endcase
      if (bus.abort) state_d = ST_IDLE;
   end

   always_ff @(posedge clk or posedge global_rst) begin
      if (global_rst) begin
         elem_q     <= '0;
         ch_fill_q  <= '0;
         ch_total_q <= '0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
      end else if (bus.abort) begin
         elem_q     <= '0;
         ch_fill_q  <= '0;
         ch_total_q <= '0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
      end else begin
         if (state_q == ST_IDLE && start_ok) begin
            ch_total_q <= ch_eff;
            ch_fill_q  <= '0;
            elem_q     <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
         end
         if (accept) begin
            if (elem_last) begin
               elem_q    <= '0;
               wr_ptr_q  <= ~wr_ptr_q;
               ch_fill_q <= ch_fill_q + CW'(1);
            end else begin
               elem_q <= elem_q + IW'(1);
            end
         end
         if (hs) rd_ptr_q <= ~rd_ptr_q;
      end
   end

   for (genvar b = 0; b < 2; b++) begin : g_bank
      logic bank_wr;
      assign bank_wr = accept & (wr_ptr_q == 1'(b));

      bram_vec_loader_bank #(
         .WIDTH  (WIDTH),
         .LENGTH (LENGTH),
         .CW     (CW)
      ) u_bank (
         .clk      (clk),
         .rst      (global_rst),
         .wr_en    (bank_wr),
         .wr_idx   (elem_q),
         .wr_data  (bus.in_data),
         .set_full (bank_wr & elem_last),
         .tag_in   (ch_fill_q),
         .last_in  (ch_last),
         .clr      (hs & (rd_ptr_q == 1'(b))),
         .flush    (bus.abort),
         .data     (bank_data[b]),
         .full     (bank_full[b]),
         .tag      (bank_tag[b]),
         .last     (bank_last[b])
      );
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = sel_full;
   assign bus.out_data  = sel_full ? sel_data : '0;
   assign bus.out_ch    = sel_full ? sel_tag : '0;
   assign bus.out_last  = sel_full & sel_last;
   assign bus.busy      = busy;
   assign bus.done      = done;

endmodule

// File: tb/tb_bram_vec_loader.sv
// Directed bench for bram_vec_loader: stimulus pushes expected vectors into a
// scoreboard queue, a negedge monitor pops and compares on every transfer.
module tb_bram_vec_loader;

   localparam int W  = 8;
   localparam int L  = 32;
   localparam int C  = 4;
   localparam int VW = W * L;

   typedef struct {
      logic [VW-1:0] d;
      logic [2:0]    ch;
      logic          last;
   } exp_t;

   logic clk = 1'b0;
   logic global_rst = 1'b1;

   bram_vec_loader_if #(.WIDTH(W), .LENGTH(L), .CHANNELS(C)) bus ();

   bram_vec_loader #(.WIDTH(W), .LENGTH(L), .CHANNELS(C)) dut (
      .clk        (clk),
      .global_rst (global_rst),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   exp_t sb[$];
   exp_t mon_e;
   int   n_chk    = 0;
   int   n_err    = 0;
   int   done_cnt = 0;
   int   stalls   = 0;

   task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] elem(input int seed, input int c, input int k);
      return 8'((seed + c * 32 + k) & 255);
   endfunction

   function automatic logic [VW-1:0] vec(input int seed, input int c);
      logic [VW-1:0] v;
      v = '0;
      for (int k = 0; k < L; k++) v[8*k +: 8] = elem(seed, c, k);
      return v;
   endfunction

   // Monitor: compare every transferred vector against the scoreboard head.
   always @(negedge clk) begin
      if (!global_rst) begin
         if (bus.done) done_cnt++;
         if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
               n_chk++;
               n_err++;
               $display("FAIL sb_underflow: got vector for ch %0d, expected none", bus.out_ch);
            end else begin
               mon_e = sb.pop_front();
               chk("vec_data", bus.out_data, mon_e.d);
               chk("vec_ch", VW'(bus.out_ch), VW'(mon_e.ch));
               chk("vec_last", VW'(bus.out_last), VW'(mon_e.last));
               chk("done_pulse", VW'(bus.done), VW'(mon_e.last));
            end
         end else if (bus.done) begin
            n_chk++;
            n_err++;
            $display("FAIL done_no_xfer: got done=1, expected 0 without transfer");
         end
      end
   end

   task automatic do_start(input int n);
      bus.start    = 1'b1;
      bus.ch_count = 3'(n);
      @(posedge clk); #1;
      bus.start    = 1'b0;
   endtask

   task automatic send(input logic [7:0] d);
      int n;
      bit acc;
      n   = 0;
      acc = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      while (!acc && n < 100) begin
         @(negedge clk);
         acc = bus.in_ready;
         @(posedge clk); #1;
         n++;
      end
      if (!acc) begin
         n_chk++;
         n_err++;
         $display("FAIL send_timeout: got no accept for %0h, expected accept within 100 cycles", d);
      end
      if (n > 1) stalls += n - 1;
   endtask

   task automatic send_chan(input int seed, input int c, input bit last);
      exp_t e;
      e.d    = vec(seed, c);
      e.ch   = 3'(c);
      e.last = last;
      sb.push_back(e);
      for (int k = 0; k < L; k++) send(elem(seed, c, k));
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (bus.busy && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      if (bus.busy) begin
         n_chk++;
         n_err++;
         $display("FAIL idle_timeout: got busy=1, expected 0 within 300 cycles");
      end
   endtask

   initial begin
      #200000;
      n_err++;
      $display("FAIL watchdog: got no completion, expected finish before time limit");
      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $fatal(1, "watchdog");
   end

   initial begin
      int d0;
      bus.start     = 1'b0;
      bus.ch_count  = '0;
      bus.abort     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 global_rst = 1'b0;

      chk("rst_out_valid", VW'(bus.out_valid), '0);
      chk("rst_in_ready", VW'(bus.in_ready), '0);
      chk("rst_busy", VW'(bus.busy), '0);
      chk("rst_done", VW'(bus.done), '0);
      chk("rst_out_data", bus.out_data, '0);
      chk("rst_out_ch_last", VW'({bus.out_ch, bus.out_last}), '0);

      // Reset mid-FILL with a vector pending
      do_start(2);
      send_chan(8'h30, 0, 1'b0);
      for (int k = 0; k < 8; k++) send(elem(8'h30, 1, k));
      chk("pre_rst_out_valid", VW'(bus.out_valid), VW'(1));
      #2 global_rst = 1'b1;
      #1;
      chk("midrst_out_valid", VW'(bus.out_valid), '0);
      chk("midrst_in_ready", VW'(bus.in_ready), '0);
      chk("midrst_busy", VW'(bus.busy), '0);
      chk("midrst_out_data", bus.out_data, '0);
      sb.delete();
      bus.in_valid = 1'b0;
      @(posedge clk); #1 global_rst = 1'b0;

      // Single channel, ramp 0x00..0x1F
      bus.out_ready = 1'b1;
      d0 = done_cnt;
      do_start(1);
      begin
         exp_t e;
         e.d = vec(0, 0); e.ch = 3'd0; e.last = 1'b1;
         sb.push_back(e);
      end
      for (int k = 0; k < L - 1; k++) send(elem(0, 0, k));
      chk("lat_before_last", VW'(bus.out_valid), '0);
      send(elem(0, 0, L - 1));
      chk("lat_after_last", VW'(bus.out_valid), VW'(1));
      bus.in_valid = 1'b0;
      wait_idle();
      chk("single_sb_empty", VW'(sb.size()), '0);
      chk("single_done_cnt", VW'(done_cnt), VW'(d0 + 1));

      // Back-to-back four channels
      stalls = 0;
      do_start(4);
      for (int c = 0; c < 4; c++) send_chan(8'h55, c, c == 3);
      bus.in_valid = 1'b0;
      chk("b2b_stalls", VW'(stalls), '0);
      wait_idle();
      chk("b2b_sb_empty", VW'(sb.size()), '0);

      // Backpressure with three channels
      bus.out_ready = 1'b0;
      do_start(3);
      send_chan(8'hA0, 0, 1'b0);
      send_chan(8'hA0, 1, 1'b0);
      begin
         exp_t e;
         e.d = vec(8'hA0, 2); e.ch = 3'd2; e.last = 1'b1;
         sb.push_back(e);
      end
      bus.in_valid = 1'b1;
      bus.in_data  = elem(8'hA0, 2, 0);
      repeat (4) begin @(posedge clk); #1; end
      chk("bp_in_ready", VW'(bus.in_ready), '0);
      chk("bp_hold_data", bus.out_data, vec(8'hA0, 0));
      chk("bp_hold_ch", VW'(bus.out_ch), '0);
      bus.out_ready = 1'b1;
      for (int k = 0; k < L; k++) send(elem(8'hA0, 2, k));
      bus.in_valid = 1'b0;
      wait_idle();
      chk("bp_sb_empty", VW'(sb.size()), '0);

      // ch_count of zero leaves IDLE alone
      do_start(0);
      chk("ch0_busy", VW'(bus.busy), '0);
      chk("ch0_in_ready", VW'(bus.in_ready), '0);

      // ch_count above max clamps; a start while busy is ignored
      do_start(7);
      fork
         begin
            repeat (40) @(posedge clk);
            #1;
            bus.start    = 1'b1;
            bus.ch_count = 3'd1;
            @(posedge clk); #1;
            bus.start    = 1'b0;
         end
      join_none
      for (int c = 0; c < 4; c++) send_chan(8'h11, c, c == 3);
      bus.in_valid = 1'b0;
      chk("clamp_in_ready", VW'(bus.in_ready), '0);
      wait_idle();
      chk("clamp_sb_empty", VW'(sb.size()), '0);

      // Abort at element 10 of channel 1
      bus.out_ready = 1'b0;
      d0 = done_cnt;
      do_start(2);
      send_chan(8'h66, 0, 1'b0);
      for (int k = 0; k < 10; k++) send(elem(8'h66, 1, k));
      bus.in_valid = 1'b1;
      bus.in_data  = elem(8'h66, 1, 10);
      bus.abort    = 1'b1;
      @(posedge clk); #1;
      bus.abort    = 1'b0;
      bus.in_valid = 1'b0;
      chk("abort_busy", VW'(bus.busy), '0);
      chk("abort_out_valid", VW'(bus.out_valid), '0);
      chk("abort_in_ready", VW'(bus.in_ready), '0);
      chk("abort_out_data", bus.out_data, '0);
      sb.delete();
      repeat (3) begin @(posedge clk); #1; end
      chk("abort_no_done", VW'(done_cnt), VW'(d0));
      bus.out_ready = 1'b1;
      do_start(1);
      send_chan(8'h77, 0, 1'b1);
      bus.in_valid = 1'b0;
      wait_idle();
      chk("post_abort_sb_empty", VW'(sb.size()), '0);
      chk("post_abort_done", VW'(done_cnt), VW'(d0 + 1));

      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end

endmodule
